// File: rtl/keypad_code_entry_pkg.sv
// Shared definitions for the keypad code-entry block: debounce FSM states,
// default special key codes and the digit nibble width.
package keypad_code_entry_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [NIBBLE_W-1:0] DEF_IDLE_CODE = 4'hF;
  localparam logic [NIBBLE_W-1:0] DEF_CLEAR_KEY = 4'hA;
  localparam logic [NIBBLE_W-1:0] DEF_BACK_KEY  = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } deb_state_e;

endpackage

// File: rtl/keypad_code_entry_if.sv
// Bundle between the keypad decoder / game logic (master) and the code-entry block (slave).
// The master drives the raw key code and lock; the slave returns key events and the collected code.
interface keypad_code_entry_if
  import keypad_code_entry_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic [NIBBLE_W-1:0]            key_code;
  logic                           lock;
  logic [NIBBLE_W*NUM_DIGITS-1:0] entered_code;
  logic [2:0]                     digit_count;
  logic                           code_entered;
  logic                           key_strobe;
  logic [NIBBLE_W-1:0]            key_value;

  modport master (
    output key_code,
    output lock,
    input  entered_code,
    input  digit_count,
    input  code_entered,
    input  key_strobe,
    input  key_value
  );

  modport slave (
    input  key_code,
    input  lock,
    output entered_code,
    output digit_count,
    output code_entered,
    output key_strobe,
    output key_value
  );

endinterface

// File: rtl/keypad_code_entry_key_debouncer.sv
// Debounces the raw key code into one event per press; the strobe appears DEBOUNCE_CYCLES
// cycles after the first stable sample. No backpressure: events are one-cycle pulses.
module key_debouncer
  import keypad_code_entry_pkg::*;
#(
  parameter int                  DEBOUNCE_CYCLES = 50000,
  parameter logic [NIBBLE_W-1:0] IDLE_CODE       = DEF_IDLE_CODE
) (
  input  logic                clock_100Mhz,
  input  logic                reset,
  input  logic [NIBBLE_W-1:0] key_code,
  output logic                accept,
  output logic [NIBBLE_W-1:0] accept_key,
  output logic                key_strobe,
  output logic [NIBBLE_W-1:0] key_value
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  deb_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic [NIBBLE_W-1:0] cand_q, cand_d;
  logic                strobe_q, strobe_d;
  logic [NIBBLE_W-1:0] value_q, value_d;

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cand_q   <= IDLE_CODE;
      strobe_q <= 1'b0;
      value_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      strobe_q <= strobe_d;
      value_q  <= value_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    value_d  = value_q;
    accept   = 1'b0;
    // Saturating increment: the counter must never wrap back into a "fresh" range.
    cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    unique case (state_q)
      ST_IDLE: begin
        if (key_code != IDLE_CODE) begin
          cand_d  = key_code;
          cnt_d   = CNT_ONE;
          state_d = ST_PRESS_WAIT;
        end
      end
      ST_PRESS_WAIT: begin
        if (key_code != cand_q) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_inc >= CNT_DONE) begin
          cnt_d   = cnt_inc;
          accept  = 1'b1;
          value_d = cand_q;
          state_d = ST_HELD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HELD: begin
        // Any non-idle code keeps the key held; a changed code is not a new press.
        if (key_code == IDLE_CODE) begin
          cnt_d   = CNT_ONE;
          state_d = ST_RELEASE_WAIT;
        end
      end
      ST_RELEASE_WAIT: begin
        if (key_code != IDLE_CODE) begin
          cnt_d   = '0;
          state_d = ST_HELD;
        end else if (cnt_inc >= CNT_DONE) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    strobe_d = accept;
  end

  assign accept_key = cand_q;
  assign key_strobe = strobe_q;
  assign key_value  = value_q;

endmodule

// File: rtl/keypad_code_entry.sv
// Collects debounced hex key presses into a NUM_DIGITS shift buffer with clear/backspace;
// buffer and code_entered update on the same edge as key_strobe. No backpressure.
module keypad_code_entry
  import keypad_code_entry_pkg::*;
#(
  parameter int                  DEBOUNCE_CYCLES = 50000,
  parameter int                  NUM_DIGITS      = 4,
  parameter logic [NIBBLE_W-1:0] IDLE_CODE       = DEF_IDLE_CODE,
  parameter logic [NIBBLE_W-1:0] CLEAR_KEY       = DEF_CLEAR_KEY,
  parameter logic [NIBBLE_W-1:0] BACK_KEY        = DEF_BACK_KEY
) (
  input  logic                clock_100Mhz,
  input  logic                reset,
  keypad_code_entry_if.slave  kif
);

  localparam int         CODE_W = NIBBLE_W * NUM_DIGITS;
  localparam logic [2:0] FULL   = 3'(NUM_DIGITS);

  logic                accept;
  logic [NIBBLE_W-1:0] accept_key;
  logic                key_strobe;
  logic [NIBBLE_W-1:0] key_value;

  logic [CODE_W-1:0]   code_q, code_d;
  logic [2:0]          count_q, count_d;
  logic                entered_q, entered_d;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .IDLE_CODE       (IDLE_CODE)
  ) u_debouncer (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .key_code     (kif.key_code),
    .accept       (accept),
    .accept_key   (accept_key),
    .key_strobe   (key_strobe),
    .key_value    (key_value)
  );

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      code_q    <= '0;
      count_q   <= '0;
      entered_q <= 1'b0;
    end else begin
      code_q    <= code_d;
      count_q   <= count_d;
      entered_q <= entered_d;
    end
  end

  always_comb begin
    code_d    = code_q;
    count_d   = count_q;
    entered_d = 1'b0;

    // lock only matters on the edge that accepts a press.
    if (accept && !kif.lock) begin
      if (accept_key == CLEAR_KEY) begin
        code_d  = '0;
        count_d = '0;
      end else if (accept_key == BACK_KEY) begin
        if (count_q != 3'd0) begin
          code_d  = code_q >> NIBBLE_W;
          count_d = count_q - 3'd1;
        end
      end else if (count_q < FULL) begin
        code_d    = {code_q[CODE_W-NIBBLE_W-1:0], accept_key};
        count_d   = count_q + 3'd1;
        entered_d = ((count_q + 3'd1) == FULL);
      end else begin
        // A digit after a complete code starts the next code from scratch.
        code_d  = {{(CODE_W-NIBBLE_W){1'b0}}, accept_key};
        count_d = 3'd1;
      end
    end
  end

  assign kif.entered_code = code_q;
  assign kif.digit_count  = count_q;
  assign kif.code_entered = entered_q;
  assign kif.key_strobe   = key_strobe;
  assign kif.key_value    = key_value;

endmodule
